// File: rtl/pipe_mul_seq.sv
`default_nettype none
// ============================================================================
// Module : pipe_mul_seq
// Shift-add MUL/MLA sequencer that borrows the shared execute-stage ALU.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mla,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] acc_in,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  nz
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ITER    = 2'd1;
  localparam logic [1:0] c_DONE    = 2'd2;
  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [5:0] c_CNT_MAX = 6'd31;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [5:0]  r_cnt;
  logic [31:0] r_result;
  logic [1:0]  r_nz;
  logic [31:0] w_mplier_shr;

  assign w_mplier_shr = r_mplier >> 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Loop ends early once no multiplier bits remain, so k tracks the operand width.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: if (start) w_state_nxt = c_ITER;
      c_ITER: begin
        if (alu_gnt && ((w_mplier_shr == 32'd0) || (r_cnt == c_CNT_MAX))) begin
          w_state_nxt = c_DONE;
        end
      end
      c_DONE:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_acc    <= 32'd0;
      r_cnt    <= 6'd0;
      r_result <= 32'd0;
      r_nz     <= 2'b00;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_mcand  <= src_a;
            r_mplier <= src_b;
            r_acc    <= mla ? acc_in : 32'd0;
            r_cnt    <= 6'd0;
          end
        end
        c_ITER: begin
          if (alu_gnt) begin
            if (r_mplier[0]) r_acc <= alu_result;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shr;
            r_cnt    <= r_cnt + 6'd1;
          end
        end
        c_DONE: begin
          r_result <= r_acc;
          r_nz     <= {r_acc[31], (r_acc == 32'd0)};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_req = 1'b0;
    alu_a   = 32'd0;
    alu_b   = 32'd0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      c_ITER: begin
        alu_req = 1'b1;
        alu_a   = r_acc;
        alu_b   = r_mcand;
        busy    = 1'b1;
      end
      c_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_ctrl = c_ALU_ADD;
  assign result   = r_result;
  assign nz       = r_nz;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mul_seq.sv
`default_nettype none
// Self-checking bench for pipe_mul_seq: arithmetic reference model, directed
// pins from the test plan, randomized operands/grant patterns and a reset abort.
module tb_pipe_mul_seq;

  logic        clk = 1'b0;
  logic        reset, start, mla, alu_gnt;
  logic [31:0] src_a, src_b, acc_in;
  logic        alu_req, busy, done;
  logic [31:0] alu_a, alu_b, alu_result, result;
  logic [2:0]  alu_ctrl;
  logic [1:0]  nz;

  int checks = 0;
  int errors = 0;
  bit exp_req = 1'b0;
  bit exp_busy = 1'b0;

  always #5 clk = ~clk;

  // Shared ALU stand-in: add, combinational.
  assign alu_result = alu_a + alu_b;

  pipe_mul_seq dut (
    .clk(clk), .reset(reset), .start(start), .mla(mla),
    .src_a(src_a), .src_b(src_b), .acc_in(acc_in),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .busy(busy), .done(done), .result(result), .nz(nz)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int iters(input logic [31:0] b);
    for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
    return 1;
  endfunction

  // Accumulator after n granted passes: base plus a times the low n multiplier bits.
  function automatic logic [31:0] partial(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return c + a * (b & m[31:0]);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("alu_ctrl", 32'(alu_ctrl), 32'd0);
      chk("alu_req", 32'(alu_req), 32'(exp_req));
      chk("busy", 32'(busy), 32'(exp_busy));
      if (!exp_req) begin
        chk("alu_a_idle", alu_a, 32'd0);
        chk("alu_b_idle", alu_b, 32'd0);
      end
    end
  end

  // gmode: 0 = continuous grant, 1 = random grant, 2 = grant low in ITER cycles 1 and 2
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic m, input int gmode, input bit noise,
                        output logic [31:0] o_res, output logic [1:0] o_nz, output int o_lat);
    int k, grants, stalls;
    logic [31:0] acc0, exp_res;
    bit fin, g;
    acc0 = m ? c : 32'd0;
    k = iters(b);
    exp_res = a * b + acc0;
    o_res = 32'd0; o_nz = 2'b00; o_lat = 0;
    start = 1'b1; src_a = a; src_b = b; acc_in = c; mla = m; alu_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom; acc_in = $urandom; mla = 1'($urandom);
    grants = 0; stalls = 0; fin = 1'b0;
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      if (grants == k) begin
        exp_req = 1'b0; exp_busy = 1'b1;
        chk("done_pulse", 32'(done), 32'd1);
        start = 1'b0; o_lat = cyc; fin = 1'b1;
        @(posedge clk); #1;
        exp_busy = 1'b0;
        chk("done_clear", 32'(done), 32'd0);
        chk("result", result, exp_res);
        chk("nz", 32'(nz), 32'({exp_res[31], (exp_res == 32'd0)}));
        o_res = result; o_nz = nz;
      end else begin
        exp_req = 1'b1; exp_busy = 1'b1;
        chk("done_early", 32'(done), 32'd0);
        chk("alu_a_iter", alu_a, partial(a, b, acc0, grants));
        chk("alu_b_iter", alu_b, a << grants);
        case (gmode)
          0:       g = 1'b1;
          1:       g = ($urandom_range(0, 3) != 0);
          default: g = !(cyc == 1 || cyc == 2);
        endcase
        alu_gnt = g;
        if (g) grants++; else stalls++;
        if (noise) begin
          start = 1'($urandom); src_a = $urandom; src_b = $urandom; acc_in = $urandom;
        end
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    if (!fin) begin
      chk("done_timeout", 32'd0, 32'd1);
      reset = 1'b1; exp_req = 1'b0; exp_busy = 1'b0;
      @(posedge clk); #1; reset = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] r, a, b, c;
    logic [1:0]  n;
    int          lat;
    bit          seen;

    reset = 1'b1; start = 1'b0; mla = 1'b0; alu_gnt = 1'b0;
    src_a = 32'd0; src_b = 32'd0; acc_in = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(alu_req), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_nz", 32'(nz), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(32'd3, 32'd5, 32'd0, 1'b0, 0, 1'b0, r, n, lat);
    chk("pin_3x5_res", r, 32'd15);
    chk("pin_3x5_lat", 32'(lat), 32'd4);
    run_op(32'd7, 32'd6, 32'd100, 1'b1, 0, 1'b0, r, n, lat);
    chk("pin_mla_res", r, 32'd142);
    chk("pin_mla_nz", 32'(n), 32'd0);
    chk("pin_mla_lat", 32'(lat), 32'd4);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 1'b0, r, n, lat);
    chk("pin_ones_res", r, 32'h0000_0001);
    chk("pin_ones_lat", 32'(lat), 32'd33);
    run_op(32'h1234_5678, 32'd0, 32'h8000_0000, 1'b1, 0, 1'b0, r, n, lat);
    chk("pin_zero_mla_res", r, 32'h8000_0000);
    chk("pin_zero_mla_nz", 32'(n), 32'd2);
    chk("pin_zero_mla_lat", 32'(lat), 32'd2);
    run_op(32'h1234_5678, 32'd0, 32'h8000_0000, 1'b0, 0, 1'b0, r, n, lat);
    chk("pin_zero_res", r, 32'd0);
    chk("pin_zero_nz", 32'(n), 32'd1);
    run_op(32'd3, 32'd5, 32'd0, 1'b0, 2, 1'b0, r, n, lat);
    chk("pin_stall_res", r, 32'd15);
    chk("pin_stall_lat", 32'(lat), 32'd6);
    run_op(32'd9, 32'd11, 32'd1, 1'b1, 0, 1'b1, r, n, lat);
    chk("pin_noise_res", r, 32'd100);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 32);
      c = $urandom;
      run_op(a, b, c, 1'($urandom), int'($urandom_range(0, 1)), bit'($urandom), r, n, lat);
    end

    // Abort in ITER cycle 2: everything drops at once, no done follows.
    run_op(32'd3, 32'd5, 32'd0, 1'b0, 0, 1'b0, r, n, lat);
    start = 1'b1; src_a = 32'd3; src_b = 32'd5; mla = 1'b0; alu_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; exp_req = 1'b1; exp_busy = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; exp_req = 1'b0; exp_busy = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_req", 32'(alu_req), 32'd0);
    chk("abort_alu_a", alu_a, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_nz", 32'(nz), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_mul_seq.md
# pipe_mul_seq

Iterative multiply sequencer for the pipelined datapath. It implements MUL and MLA by running a shift-add loop through the shared 32-bit execute-stage ALU, one adder pass per cycle, and requests the ALU for every loop cycle. It stalls the pipeline while busy and returns a 32-bit product (low word) with N/Z flags. It sits beside the execute stage, and the execute-stage mux selects its ALU operands when it is granted.

## Interface
- No parameters; datapath width fixed at 32 bits, iteration limit fixed at 32.
- Reset is asynchronous and active-high; there is one clock.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers
- start  in  1  request new multiply; sampled only in IDLE
- mla  in  1  1 = multiply-accumulate (add acc_in), 0 = plain MUL
- src_a  in  32  multiplicand
- src_b  in  32  multiplier
- acc_in  in  32  accumulate operand, used only when mla=1
- alu_req  out  1  requests the shared ALU for this cycle
- alu_gnt  in  1  ALU granted this cycle; iteration advances only when 1
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_ctrl  out  3  ALU control; always 3'b000 (add)
- alu_result  in  32  ALU Result, combinational from alu_a/alu_b
- busy  out  1  operation in progress; pipeline stall request
- done  out  1  one-cycle pulse; result/nz valid
- result  out  32  low 32 bits of src_a*src_b (+acc_in)
- nz  out  2  {N,Z} of result; C/V are not produced

## Operation
- Registers: state, mcand[31:0], mplier[31:0], acc[31:0], cnt[5:0], result, nz.
- States: IDLE, ITER, DONE.
- IDLE with start=1: load mcand<=src_a, mplier<=src_b, acc<=mla?acc_in:0, cnt<=0, and go to ITER. With start=0, stay in IDLE.
- ITER and alu_gnt=1:
  - if mplier[0], acc<=alu_result; otherwise acc is unchanged.
  - mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - go to DONE when (mplier>>1)==0 or cnt==31; otherwise stay in ITER.
- ITER and alu_gnt=0: all registers hold and state stays ITER.
- DONE: result<=acc, nz<={acc[31], acc==0}, done=1 for this cycle, then return to IDLE.
- alu_req=1 only in ITER. alu_a=acc and alu_b=mcand in ITER; both are 0 otherwise. alu_ctrl is always 000.
- ALU carry and overflow are ignored, so arithmetic wraps modulo 2^32. Signed and unsigned operands give the same low word.
- start is ignored while busy; no queueing.
- result and nz hold their values until the next DONE.

## Timing
- Reset values: state=IDLE, busy=0, done=0, alu_req=0, alu_a=0, alu_b=0, alu_ctrl=000, result=0, nz=00, and all internal registers 0.
- busy=1 in ITER and DONE; it rises the cycle after start is accepted.
- Iteration count: k = max(1, position of highest set bit of src_b + 1). Zero multiplier gives k=1; bit31 set gives k=32.
- Latency with a continuous grant: start sampled at edge T, ITER for k cycles, DONE at cycle T+1+k. result/nz become visible after the DONE edge.
- Each cycle with alu_gnt=0 during ITER adds exactly one cycle of latency.
- Back-to-back: start may be accepted in the IDLE cycle immediately following DONE.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at their reset values. No done pulse is produced and no partial result is kept.

## Test plan
- 3*5, mla=0, gnt=1: k=3; done at T+4; result=15, nz=00.
- MLA 7*6+100, gnt=1: result=142, nz=00; done at T+4.
- 0xFFFFFFFF*0xFFFFFFFF: 32 ITER cycles; done at T+33; result=0x00000001, nz=00.
- src_b=0, mla=1, acc_in=0x80000000: k=1; done at T+2; result=0x80000000, nz=10. Repeat with mla=0: result=0, nz=01.
- 3*5 with alu_gnt low in ITER cycles 1 and 2: done at T+6; result=15. Registers must hold while gnt=0; check that alu_req stays high throughout.
- start pulsed while busy: ignored, first result unaffected. Reset asserted in ITER cycle 2: busy, done and alu_req drop to 0 immediately; result=0, and no done pulse follows.
